// File: rtl/prbs7_sync_checker.sv
// PRBS7 (x^7+x^6+1) self-synchronizing serial bit checker.
// Seeds from the received stream, locks after LOCK_CNT correct predictions,
// then flags and counts mismatches with saturating counters.
// Optional macro PRBS7_CHK_INVERT_EN adds an 'inv' input that inverts din
// before both the shift register and the comparison.
module prbs7_sync_checker #(
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned RESYNC_ERRS = 4,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
`ifdef PRBS7_CHK_INVERT_EN
  input  logic                 inv,
`endif
  input  logic                 din,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ERR_CNT_W-1:0] bit_cnt
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSeed   = 2'd1;
  localparam logic [1:0] StSync   = 2'd2;
  localparam logic [1:0] StLocked = 2'd3;

  localparam logic [7:0]           LockCnt    = LOCK_CNT[7:0];
  localparam logic [3:0]           ResyncErrs = RESYNC_ERRS[3:0];
  localparam logic [ERR_CNT_W-1:0] CntOne     = 1;

  logic [1:0]           state_q, state_d;
  logic [6:0]           sr_q, sr_d;
  logic [2:0]           seed_q, seed_d;
  logic [7:0]           match_q, match_d;
  logic [3:0]           cons_q, cons_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_CNT_W-1:0] bit_cnt_q, bit_cnt_d;

  logic                 bit_in;
  logic                 pred;
  logic                 hit;
  logic [7:0]           match_inc;
  logic [3:0]           cons_inc;

`ifdef PRBS7_CHK_INVERT_EN
  assign bit_in = din ^ inv;
`else
  assign bit_in = din;
`endif

  assign pred      = sr_q[6] ^ sr_q[5];
  assign hit       = (bit_in == pred);
  assign match_inc = match_q + 8'd1;
  assign cons_inc  = cons_q + 4'd1;

  // Next-state: shift on every enabled edge, then per-state sequencing
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    seed_d    = seed_q;
    match_d   = match_q;
    cons_d    = cons_q;
    locked_d  = locked_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;

    if (!en) begin
      // Idle keeps the error verdict; only reset clears it
      state_d  = StIdle;
      seed_d   = 3'd0;
      match_d  = 8'd0;
      cons_d   = 4'd0;
      locked_d = 1'b0;
    end else begin
      sr_d = {sr_q[5:0], bit_in};
      case (state_q)
        // The enabling edge in IDLE already captures the first seed bit
        StIdle, StSeed: begin
          if (seed_q == 3'd6) begin
            state_d = StSync;
            seed_d  = 3'd0;
            match_d = 8'd0;
          end else begin
            state_d = StSeed;
            seed_d  = seed_q + 3'd1;
          end
        end
        StSync: begin
          // An all-zero register predicts zeros forever; never count that as a match
          if (hit && (sr_q != 7'd0)) begin
            if (match_inc == LockCnt) begin
              state_d  = StLocked;
              locked_d = 1'b1;
              match_d  = 8'd0;
              cons_d   = 4'd0;
            end else begin
              match_d = match_inc;
            end
          end else begin
            match_d = 8'd0;
          end
        end
        StLocked: begin
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CntOne;
          if (!hit) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CntOne;
            if (cons_inc == ResyncErrs) begin
              state_d  = StSync;
              locked_d = 1'b0;
              match_d  = 8'd0;
              cons_d   = 4'd0;
            end else begin
              cons_d = cons_inc;
            end
          end else begin
            cons_d = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sr_q      <= 7'd0;
      seed_q    <= 3'd0;
      match_q   <= 8'd0;
      cons_q    <= 4'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      seed_q    <= seed_d;
      match_q   <= match_d;
      cons_q    <= cons_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs7_sync_checker.sv
// Directed testbench for prbs7_sync_checker (default parameters).
module tb_prbs7_sync_checker;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        din;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [15:0] bit_cnt;

  int n_checks;
  int n_errors;
  logic [6:0] tx;     // transmitter LFSR history, newest bit in [0]
  logic       ever_locked;

  prbs7_sync_checker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
`ifdef PRBS7_CHK_INVERT_EN
    .inv     (1'b0),
`endif
    .din     (din),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .bit_cnt (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one bit and advance past the next rising edge
  task automatic tick(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  // Send next transmitter bit, optionally corrupted on the wire only
  task automatic send(input logic flip);
    logic b;
    b  = tx[6] ^ tx[5];
    tx = {tx[5:0], b};
    tick(b ^ flip);
  endtask

  // Send an inverted bit that the transmitter itself adopts (new stream phase)
  task automatic send_inv_adopt();
    logic b;
    b  = ~(tx[6] ^ tx[5]);
    tx = {tx[5:0], b};
    tick(b);
  endtask

  task automatic do_reset();
    en    = 1'b0;
    din   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Seed with 7'h7F then 8 predictable bits: lock exactly at the 15th edge
  task automatic seed_and_lock();
    tx = 7'h7F;
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick(1'b1);
    for (int i = 0; i < 8; i++) send(1'b0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    ever_locked = 1'b0;
    tx          = 7'h7F;
    en          = 1'b0;
    din         = 1'b0;
    rst_n       = 1'b0;
    #3;
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("rst_bit_cnt", {16'd0, bit_cnt}, 32'd0);
    do_reset();

    // Clean stream: lock at edge 15, then 500 error-free bits
    tx = 7'h7F;
    en = 1'b1;
    for (int i = 0; i < 7; i++) tick(1'b1);
    for (int i = 0; i < 7; i++) send(1'b0);
    check("lock_edge14", {31'd0, locked}, 32'd0);
    send(1'b0);
    check("lock_edge15", {31'd0, locked}, 32'd1);
    check("lock_bit_cnt0", {16'd0, bit_cnt}, 32'd0);
    for (int i = 0; i < 500; i++) send(1'b0);
    check("clean_err", {31'd0, err}, 32'd0);
    check("clean_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("clean_bit_cnt", {16'd0, bit_cnt}, 32'd500);

    // Single flipped bit at position 100: three isolated mismatches
    for (int i = 0; i < 99; i++) send(1'b0);
    send(1'b1);
    check("flip_err_now", {16'd0, err_cnt}, 32'd1);
    for (int i = 0; i < 20; i++) send(1'b0);
    check("flip_err", {31'd0, err}, 32'd1);
    check("flip_err_cnt", {16'd0, err_cnt}, 32'd3);
    check("flip_locked", {31'd0, locked}, 32'd1);
    check("flip_bit_cnt", {16'd0, bit_cnt}, 32'd620);

    // Four consecutive inverted bits force resync; relock 8 edges later
    do_reset();
    seed_and_lock();
    for (int i = 0; i < 20; i++) send(1'b0);
    for (int i = 0; i < 3; i++) send_inv_adopt();
    check("resync_3rd_locked", {31'd0, locked}, 32'd1);
    send_inv_adopt();
    check("resync_4th_locked", {31'd0, locked}, 32'd0);
    check("resync_err_cnt", {16'd0, err_cnt}, 32'd4);
    for (int i = 0; i < 7; i++) send(1'b0);
    check("relock_7", {31'd0, locked}, 32'd0);
    send(1'b0);
    check("relock_8", {31'd0, locked}, 32'd1);
    check("relock_err_cnt", {16'd0, err_cnt}, 32'd4);

    // All-zero input never locks and never flags errors
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1'b0);
      if (locked) ever_locked = 1'b1;
    end
    check("zeros_never_locked", {31'd0, ever_locked}, 32'd0);
    check("zeros_err", {31'd0, err}, 32'd0);

    // en drop: idle clears lock, keeps counters; relock 15 edges after re-enable
    do_reset();
    seed_and_lock();
    for (int i = 0; i < 10; i++) send(1'b0);
    send(1'b1);
    for (int i = 0; i < 10; i++) send(1'b0);
    check("pre_idle_err_cnt", {16'd0, err_cnt}, 32'd3);
    en = 1'b0;
    tick(1'b0);
    check("idle_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 9; i++) tick(1'b1);
    check("idle_err_cnt", {16'd0, err_cnt}, 32'd3);
    check("idle_bit_cnt", {16'd0, bit_cnt}, 32'd21);
    check("idle_err", {31'd0, err}, 32'd1);
    en = 1'b1;
    for (int i = 0; i < 14; i++) send(1'b0);
    check("reen_edge14", {31'd0, locked}, 32'd0);
    send(1'b0);
    check("reen_edge15", {31'd0, locked}, 32'd1);

    // Asynchronous reset mid-stream clears outputs before the next edge
    din = tx[6] ^ tx[5];
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_locked", {31'd0, locked}, 32'd0);
    check("arst_err", {31'd0, err}, 32'd0);
    check("arst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check("arst_bit_cnt", {16'd0, bit_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
